// File: rtl/ezusb_slave_fifo_pkg.sv
// Shared FX2 slave-FIFO constants: endpoint fifoaddr codes and bus byte width.
package ezusb_slave_fifo_pkg;
   localparam int BYTE_W = 8;
   localparam logic [1:0] EP2_FIFOADDR = 2'b00;
   localparam logic [1:0] EP4_FIFOADDR = 2'b01;
   localparam logic [1:0] EP6_FIFOADDR = 2'b10;
   localparam logic [1:0] EP8_FIFOADDR = 2'b11;
endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a registered head byte (0 when empty) and a post-update count.
module sync_byte_fifo
   import ezusb_slave_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count_next,
   output logic [BYTE_W-1:0] head
);
   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
   logic [AW:0]       cnt;
   logic              push_ok, pop_ok;
   logic [BYTE_W-1:0] head_next;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   // A pop on empty is dropped; a push on full only lands when a pop frees the slot.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rd_next = rd_ptr + AW'(pop_ok);

   always_comb begin
      count_next = cnt;
      if (push_ok & ~pop_ok)
         count_next = cnt + (AW+1)'(1);
      else if (pop_ok & ~push_ok)
         count_next = cnt - (AW+1)'(1);
   end

   // The incoming byte is forwarded when it becomes the new head in the same edge.
   always_comb begin
      head_next = mem[rd_next];
      if (count_next == '0)
         head_next = '0;
      else if (push_ok && (wr_ptr == rd_next))
         head_next = din;
   end

   always_ff @(posedge clk)
      if (!rst && push_ok)
         mem[wr_ptr] <= din;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_next;
         cnt    <= count_next;
         head   <= head_next;
      end
   end
endmodule

// File: rtl/ezusb_slave_fifo.sv
// EZ-USB FX2 slave-FIFO responder: EP2 OUT (host->master) and EP6 IN (master->host) buffers.
module ezusb_slave_fifo
   import ezusb_slave_fifo_pkg::*;
#(
   parameter int         DEPTH    = 8,
   parameter int         AW       = 3,
   parameter logic [1:0] EP2_ADDR = EP2_FIFOADDR,
   parameter logic [1:0] EP6_ADDR = EP6_FIFOADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] data_i,
   input  logic              data_en,
   output logic [BYTE_W-1:0] data_o,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              oe_n,
   input  logic [1:0]        fifoaddr,
   output logic              ep2out_emptyp1_n,
   output logic              ep6in_full_n,
   output logic              ep6in_fullm2_n,
   input  logic [BYTE_W-1:0] host_out_data,
   input  logic              host_out_valid,
   output logic              host_out_ready,
   output logic [BYTE_W-1:0] host_in_data,
   output logic              host_in_valid,
   input  logic              host_in_ready,
   output logic              err_underrun,
   output logic              err_overrun
);
   logic          m_rd, m_wr, h_push, h_pop;
   logic          ep2_full, ep2_empty, ep6_full, ep6_empty;
   logic [AW:0]   cnt2_next, cnt6_next;

   // oe_n decides direction, so a cycle with both strobes low resolves to one access.
   assign m_rd   = ~rd_n & ~oe_n & (fifoaddr == EP2_ADDR);
   assign m_wr   = ~wr_n &  oe_n & data_en & (fifoaddr == EP6_ADDR);
   assign h_push = host_out_valid & host_out_ready;
   assign h_pop  = host_in_valid & host_in_ready;

   assign host_out_ready = ~ep2_full;
   assign host_in_valid  = ~ep6_empty;

   sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_ep2 (
      .clk(clk), .rst(rst), .push(h_push), .din(host_out_data), .pop(m_rd),
      .full(ep2_full), .empty(ep2_empty), .count_next(cnt2_next), .head(data_o)
   );

   sync_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_ep6 (
      .clk(clk), .rst(rst), .push(m_wr), .din(data_i), .pop(h_pop),
      .full(ep6_full), .empty(ep6_empty), .count_next(cnt6_next), .head(host_in_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ep2out_emptyp1_n <= 1'b0;
         ep6in_full_n     <= 1'b1;
         ep6in_fullm2_n   <= 1'b1;
         err_underrun     <= 1'b0;
         err_overrun      <= 1'b0;
      end else begin
         ep2out_emptyp1_n <= (cnt2_next > (AW+1)'(1));
         ep6in_full_n     <= (cnt6_next < (AW+1)'(DEPTH));
         ep6in_fullm2_n   <= (cnt6_next < (AW+1)'(DEPTH-2));
         if (m_rd && ep2_empty)
            err_underrun <= 1'b1;
         if (m_wr && ep6_full && !h_pop)
            err_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ezusb_slave_fifo.sv
// Directed bench for ezusb_slave_fifo (DEPTH=8) with hand-computed expectations.
module tb_ezusb_slave_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_i = '0, data_o, host_out_data = '0, host_in_data;
   logic       data_en = 1'b0, rd_n = 1'b1, wr_n = 1'b1, oe_n = 1'b1;
   logic [1:0] fifoaddr = 2'b00;
   logic       ep2out_emptyp1_n, ep6in_full_n, ep6in_fullm2_n;
   logic       host_out_valid = 1'b0, host_out_ready, host_in_valid, host_in_ready = 1'b0;
   logic       err_underrun, err_overrun;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   ezusb_slave_fifo #(.DEPTH(8), .AW(3), .EP2_ADDR(2'b00), .EP6_ADDR(2'b10)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .data_en(data_en), .data_o(data_o),
      .rd_n(rd_n), .wr_n(wr_n), .oe_n(oe_n), .fifoaddr(fifoaddr),
      .ep2out_emptyp1_n(ep2out_emptyp1_n), .ep6in_full_n(ep6in_full_n),
      .ep6in_fullm2_n(ep6in_fullm2_n), .host_out_data(host_out_data),
      .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
      .host_in_data(host_in_data), .host_in_valid(host_in_valid),
      .host_in_ready(host_in_ready), .err_underrun(err_underrun), .err_overrun(err_overrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " emptyp1_n"}, 32'(ep2out_emptyp1_n), 0);
      chk({tag, " full_n"},    32'(ep6in_full_n), 1);
      chk({tag, " fullm2_n"},  32'(ep6in_fullm2_n), 1);
      chk({tag, " out_ready"}, 32'(host_out_ready), 1);
      chk({tag, " in_valid"},  32'(host_in_valid), 0);
      chk({tag, " data_o"},    32'(data_o), 0);
      chk({tag, " in_data"},   32'(host_in_data), 0);
      chk({tag, " underrun"},  32'(err_underrun), 0);
      chk({tag, " overrun"},   32'(err_overrun), 0);
   endtask

   task automatic host_push(input logic [7:0] b);
      host_out_data = b; host_out_valid = 1'b1;
      step();
      host_out_valid = 1'b0;
   endtask

   initial begin
      // 1. reset
      step(); step();
      rst = 1'b0;
      step();
      chk_reset_state("reset");

      // 2. host pushes 01..03, master reads them back
      host_push(8'h01);
      chk("t2 data_o after 1", 32'(data_o), 32'h01);
      chk("t2 emptyp1 cnt1", 32'(ep2out_emptyp1_n), 0);
      host_push(8'h02);
      chk("t2 emptyp1 cnt2", 32'(ep2out_emptyp1_n), 1);
      host_push(8'h03);
      rd_n = 1'b0; oe_n = 1'b0; fifoaddr = 2'b00;
      chk("t2 rd0 data", 32'(data_o), 32'h01);
      step();
      chk("t2 rd1 data", 32'(data_o), 32'h02);
      chk("t2 emptyp1 cnt2b", 32'(ep2out_emptyp1_n), 1);
      step();
      chk("t2 rd2 data", 32'(data_o), 32'h03);
      chk("t2 emptyp1 cnt1b", 32'(ep2out_emptyp1_n), 0);
      step();
      rd_n = 1'b1; oe_n = 1'b1;
      chk("t2 data_o empty", 32'(data_o), 0);
      chk("t2 no underrun", 32'(err_underrun), 0);

      // 3. master fills EP6 with A0..A7, 9th write overruns, host drains
      wr_n = 1'b0; oe_n = 1'b1; data_en = 1'b1; fifoaddr = 2'b10;
      for (int i = 0; i < 8; i++) begin
         data_i = 8'hA0 + 8'(i);
         step();
         chk($sformatf("t3 fullm2_n w%0d", i + 1), 32'(ep6in_fullm2_n), 32'(i + 1 < 6));
         chk($sformatf("t3 full_n w%0d", i + 1), 32'(ep6in_full_n), 32'(i + 1 < 8));
      end
      chk("t3 in_valid", 32'(host_in_valid), 1);
      chk("t3 no overrun yet", 32'(err_overrun), 0);
      data_i = 8'hA8;
      step();
      chk("t3 overrun", 32'(err_overrun), 1);
      wr_n = 1'b1; data_en = 1'b0;
      host_in_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3 pop%0d", i), 32'(host_in_data), 32'hA0 + 32'(i));
         step();
      end
      host_in_ready = 1'b0;
      chk("t3 drained valid", 32'(host_in_valid), 0);
      chk("t3 drained full_n", 32'(ep6in_full_n), 1);
      chk("t3 drained fullm2_n", 32'(ep6in_fullm2_n), 1);

      // 4. master read on empty EP2
      rd_n = 1'b0; oe_n = 1'b0; fifoaddr = 2'b00;
      step();
      rd_n = 1'b1; oe_n = 1'b1;
      chk("t4 underrun", 32'(err_underrun), 1);
      chk("t4 data_o", 32'(data_o), 0);
      host_push(8'h5A);
      host_push(8'h5B);
      chk("t4 cnt0 then 2 head", 32'(data_o), 32'h5A);
      chk("t4 cnt0 then 2 emptyp1", 32'(ep2out_emptyp1_n), 1);

      // 6. reset with bytes in EP2 and strobes active
      for (int i = 0; i < 3; i++) host_push(8'h11 + 8'(i));
      rst = 1'b1; rd_n = 1'b0; oe_n = 1'b0; fifoaddr = 2'b00;
      host_out_data = 8'hEE; host_out_valid = 1'b1;
      step();
      rst = 1'b0; rd_n = 1'b1; oe_n = 1'b1; host_out_valid = 1'b0;
      step();
      chk_reset_state("t6 rst");
      host_push(8'h77);
      chk("t6 first after rst", 32'(data_o), 32'h77);
      rd_n = 1'b0; oe_n = 1'b0; fifoaddr = 2'b01;
      step();
      chk("t6 bad addr rd", 32'(data_o), 32'h77);
      rd_n = 1'b1; oe_n = 1'b1; wr_n = 1'b0; data_en = 1'b1; data_i = 8'h99;
      step();
      wr_n = 1'b1; data_en = 1'b0;
      chk("t6 bad addr wr", 32'(host_in_valid), 0);
      rd_n = 1'b0; oe_n = 1'b0; fifoaddr = 2'b00;
      step();
      rd_n = 1'b1; oe_n = 1'b1;
      chk("t6 read 77 empties", 32'(data_o), 0);
      chk("t6 no underrun", 32'(err_underrun), 0);

      // 5. EP6 full, simultaneous master write and host pop
      wr_n = 1'b0; oe_n = 1'b1; data_en = 1'b1; fifoaddr = 2'b10;
      for (int i = 0; i < 8; i++) begin
         data_i = 8'hC0 + 8'(i);
         step();
      end
      chk("t5 full", 32'(ep6in_full_n), 0);
      data_i = 8'hC8; host_in_ready = 1'b1;
      chk("t5 head C0", 32'(host_in_data), 32'hC0);
      step();
      wr_n = 1'b1; data_en = 1'b0;
      chk("t5 still full", 32'(ep6in_full_n), 0);
      chk("t5 no overrun", 32'(err_overrun), 0);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("t5 pop%0d", i), 32'(host_in_data), 32'hC0 + 32'(i));
         step();
      end
      host_in_ready = 1'b0;
      chk("t5 empty", 32'(host_in_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
